// File: rtl/calc_input_sequencer.sv
// Keypad entry sequencer for a 4-bit add/subtract calculator.
// Collects operand A, operator and operand B from key presses, then drives an
// external adder/subtractor and registers its result. Results can be chained.
// Optional build macro CALC_SEQ_TIMEOUT_EN abandons partial entries after
// TIMEOUT_CYCLES idle cycles; without it no timeout logic is built.
module calc_input_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [4:0] key_code,
    output logic       key_ready,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic       mode,
    input  logic [3:0] add_sum,
    input  logic       add_cout,
    output logic [3:0] result,
    output logic       result_valid,
    output logic       result_flag
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GOT_A  = 3'd1,
        GOT_OP = 3'd2,
        GOT_B  = 3'd3,
        EXEC   = 3'd4,
        SHOW   = 3'd5
    } state_t;

    state_t     state, state_d;
    logic [3:0] op_a_d, op_b_d, result_d;
    logic       mode_d, result_valid_d, result_flag_d;

    logic accept, is_digit, is_plus, is_minus, is_op, is_eq, is_clr;
    logic timeout, clear;

    // Key decode; reserved codes decode to nothing and are simply swallowed
    assign accept   = key_valid && key_ready;
    assign is_digit = accept && !key_code[4];
    assign is_plus  = accept && (key_code == 5'h10);
    assign is_minus = accept && (key_code == 5'h11);
    assign is_op    = is_plus || is_minus;
    assign is_eq    = accept && (key_code == 5'h12);
    assign is_clr   = accept && (key_code == 5'h13);
    assign clear    = is_clr || timeout;

`ifdef CALC_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] idle_cnt;
    logic             partial;

    assign partial = (state == GOT_A) || (state == GOT_OP) || (state == GOT_B);
    // An accepted key on the expiring cycle wins over the timeout
    assign timeout = partial && !accept && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter for partial entries, cleared by any accepted key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (accept || !partial || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (is_digit) state_d = GOT_A;  else if (is_op) state_d = GOT_OP;
            GOT_A:   if (is_op)    state_d = GOT_OP;
            GOT_OP:  if (is_digit) state_d = GOT_B;
            GOT_B:   if (is_eq)    state_d = EXEC;
            EXEC:                  state_d = SHOW;
            SHOW:    if (is_digit) state_d = GOT_A;  else if (is_op) state_d = GOT_OP;
            default:               state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
        end
    end

    // Next values of the registered datapath outputs
    always_comb begin
        op_a_d         = op_a;
        op_b_d         = op_b;
        mode_d         = mode;
        result_d       = result;
        result_valid_d = result_valid;
        result_flag_d  = result_flag;
        case (state)
            IDLE: begin
                if (is_digit) begin
                    op_a_d = key_code[3:0];
                end else if (is_op) begin
                    op_a_d = 4'd0;
                    mode_d = is_minus;
                end
            end
            GOT_A: begin
                if (is_digit) op_a_d = key_code[3:0];
                else if (is_op) mode_d = is_minus;
            end
            GOT_OP: begin
                if (is_op) mode_d = is_minus;
                else if (is_digit) op_b_d = key_code[3:0];
            end
            GOT_B: begin
                if (is_digit) op_b_d = key_code[3:0];
            end
            EXEC: begin
                result_d       = add_sum;
                result_flag_d  = mode ? ~add_cout : add_cout;
                result_valid_d = 1'b1;
            end
            SHOW: begin
                if (is_op) begin
                    op_a_d         = result;
                    mode_d         = is_minus;
                    result_valid_d = 1'b0;
                end else if (is_digit) begin
                    op_a_d         = key_code[3:0];
                    result_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (clear) begin
            op_a_d         = 4'd0;
            op_b_d         = 4'd0;
            mode_d         = 1'b0;
            result_d       = 4'd0;
            result_valid_d = 1'b0;
            result_flag_d  = 1'b0;
        end
    end

    // Output registers; key_ready is registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a         <= 4'd0;
            op_b         <= 4'd0;
            mode         <= 1'b0;
            result       <= 4'd0;
            result_valid <= 1'b0;
            result_flag  <= 1'b0;
            key_ready    <= 1'b1;
        end else begin
            op_a         <= op_a_d;
            op_b         <= op_b_d;
            mode         <= mode_d;
            result       <= result_d;
            result_valid <= result_valid_d;
            result_flag  <= result_flag_d;
            key_ready    <= (state_d != EXEC);
        end
    end

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Directed bench for calc_input_sequencer with a behavioural adder/subtractor.
module tb_calc_input_sequencer;

    localparam logic [4:0] K_PLUS  = 5'h10;
    localparam logic [4:0] K_MINUS = 5'h11;
    localparam logic [4:0] K_EQ    = 5'h12;
    localparam logic [4:0] K_CLR   = 5'h13;
    localparam logic [4:0] K_RSVD  = 5'h1F;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid;
    logic [4:0] key_code;
    logic       key_ready;
    logic [3:0] op_a, op_b, result, add_sum;
    logic       mode, add_cout, result_valid, result_flag;
    logic [4:0] add_full;

    int checks = 0;
    int errors = 0;

    calc_input_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ready    (key_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .mode         (mode),
        .add_sum      (add_sum),
        .add_cout     (add_cout),
        .result       (result),
        .result_valid (result_valid),
        .result_flag  (result_flag)
    );

    always #5 clk = ~clk;

    // Downstream adder: subtract is a + ~b + 1, carry-out 1 means no borrow
    always_comb begin
        if (mode) add_full = {1'b0, op_a} + {1'b0, ~op_b} + 5'd1;
        else      add_full = {1'b0, op_a} + {1'b0, op_b};
        add_sum  = add_full[3:0];
        add_cout = add_full[4];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [4:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 5'h00;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 5'h00;
        #1;
        chk("rst_op_a", 32'(op_a), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        // key held during reset must be lost
        key_valid = 1'b1;
        key_code  = 5'h03;
        repeat (3) @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0;
        rst_n     = 1'b1;
        #1;
        chk("rst_ready", 32'(key_ready), 32'd1);
        chk("rst_all", 32'({op_a, op_b, mode, result, result_valid, result_flag}), 32'd0);

        // 7 + 5 = 12
        press(5'd7); press(K_PLUS); press(5'd5); press(K_EQ);
        chk("t1_operands", 32'({op_a, op_b, mode}), 32'({4'd7, 4'd5, 1'b0}));
        chk("t1_exec_ready", 32'(key_ready), 32'd0);
        chk("t1_not_yet", 32'(result_valid), 32'd0);
        edge1();
        chk("t1_result", 32'({result, result_flag, result_valid}), 32'({4'd12, 1'b0, 1'b1}));
        chk("t1_show_ready", 32'(key_ready), 32'd1);

        // 3 - 5 = 14 with borrow, then chain + 2 = 0 with carry
        press(K_CLR);
        chk("t2_clear", 32'({op_a, op_b, mode, result, result_valid, result_flag}), 32'd0);
        press(5'd3); press(K_MINUS); press(5'd5); press(K_EQ); edge1();
        chk("t2_sub", 32'({result, result_flag, result_valid}), 32'({4'd14, 1'b1, 1'b1}));
        press(K_PLUS);
        chk("t2_chain", 32'({op_a, mode, result_valid}), 32'({4'd14, 1'b0, 1'b0}));
        press(5'd2); press(K_EQ); edge1();
        chk("t2_wrap", 32'({op_a, result, result_flag, result_valid}), 32'({4'd14, 4'd0, 1'b1, 1'b1}));

        // 9 + 9 = 2 carry; digit in SHOW starts a fresh entry
        press(5'd9);
        chk("t3_fresh", 32'({op_a, result_valid}), 32'({4'd9, 1'b0}));
        press(K_PLUS); press(5'd9); press(K_EQ); edge1();
        chk("t3_carry", 32'({result, result_flag}), 32'({4'd2, 1'b1}));

        // Replacement of operands and operator; reserved code ignored
        press(K_CLR);
        press(5'd4); press(K_RSVD);
        chk("t4_rsvd", 32'(op_a), 32'd4);
        press(5'd6); press(K_MINUS); press(K_PLUS); press(5'd9); press(5'd1);
        press(K_PLUS);
        press(K_EQ);
        chk("t4_operands", 32'({op_a, mode, op_b}), 32'({4'd6, 1'b0, 4'd1}));
        edge1();
        chk("t4_result", 32'({result, result_flag, result_valid}), 32'({4'd7, 1'b0, 1'b1}));

        // Clear mid entry, '=' afterwards does nothing
        press(K_CLR);
        press(5'd8); press(K_PLUS); press(K_CLR);
        chk("t5_clr", 32'({op_a, op_b, mode, result, result_valid, result_flag}), 32'd0);
        press(K_EQ); edge1();
        chk("t5_no_pulse", 32'({result_valid, op_a}), 32'd0);

        // Asynchronous reset in GOT_B
        press(5'd1); press(K_PLUS); press(5'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_async", 32'({op_a, op_b, mode}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        press(5'd2); press(K_PLUS); press(5'd2); press(K_EQ); edge1();
        chk("t6_after", 32'({result, result_valid}), 32'({4'd4, 1'b1}));

        // Reset while in EXEC discards the computation
        press(K_CLR);
        press(5'd1); press(K_PLUS); press(5'd1); press(K_EQ);
        rst_n = 1'b0;
        edge1();
        chk("t7_exec_rst", 32'({result, result_valid}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef CALC_SEQ_TIMEOUT_EN
        // Entry abandoned after 8 idle cycles
        press(5'd5);
        repeat (7) edge1();
        chk("t8_before_to", 32'(op_a), 32'd5);
        edge1();
        chk("t8_timeout", 32'(op_a), 32'd0);
        // Key on the eighth cycle keeps the entry
        press(5'd5);
        repeat (7) edge1();
        press(K_MINUS);
        chk("t8_key_wins", 32'({op_a, mode}), 32'({4'd5, 1'b1}));
        repeat (5) edge1();
        chk("t8_restart", 32'(op_a), 32'd5);
`else
        // Partial entry persists indefinitely
        press(5'd5);
        repeat (20) edge1();
        chk("t8_persist", 32'(op_a), 32'd5);
        press(K_MINUS);
        chk("t8_resume", 32'({op_a, mode}), 32'({4'd5, 1'b1}));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
